// File: rtl/enemy_ctrl_pkg.sv
// Shared state encoding and bit-scan helpers for the enemy wave sequencer.
package enemy_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARMED  = 3'd1;
  localparam logic [2:0] ST_LATCH  = 3'd2;
  localparam logic [2:0] ST_DRAW   = 3'd3;
  localparam logic [2:0] ST_DELAY  = 3'd4;
  localparam logic [2:0] ST_ERASE  = 3'd5;
  localparam logic [2:0] ST_UPDATE = 3'd6;

  localparam int MAX_ENEMY = 16;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } bit_sel_t;

  // Lowest set bit strictly above idx; the descending scan leaves the lowest hit.
  function automatic bit_sel_t next_set(input logic [MAX_ENEMY-1:0] mask,
                                        input logic [3:0] idx);
    bit_sel_t r;
    r = '0;
    for (int i = MAX_ENEMY - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(idx))) begin
        r.valid = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

  function automatic bit_sel_t first_set(input logic [MAX_ENEMY-1:0] mask);
    bit_sel_t r;
    r = '0;
    for (int i = MAX_ENEMY - 1; i >= 0; i--) begin
      if (mask[i]) begin
        r.valid = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_delay_cnt.sv
// Down-counter that spaces the draw and erase phases; holds at zero until reloaded.
module frame_delay_cnt #(
  parameter int CNT_W     = 20,
  parameter int DELAY_CYC = 833333
) (
  input  logic clk,
  input  logic reset_N,
  input  logic load,
  input  logic en,
  output logic zero
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= CNT_W'(DELAY_CYC - 1);
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/enemy_wave_ctrl.sv
// Per-frame draw / delay / erase / update sequencer for a wave of enemies
// sharing one pixel drawer.
module enemy_wave_ctrl
  import enemy_ctrl_pkg::*;
#(
  parameter int N_ENEMY   = 4,
  parameter int IDX_W     = 2,
  parameter int DELAY_CYC = 833333,
  parameter int CNT_W     = 20
) (
  input  logic               clk,
  input  logic               reset_N,
  input  logic               go,
  input  logic               done,
  input  logic               pause,
  input  logic [N_ENEMY-1:0] alive,
  output logic [IDX_W-1:0]   sel,
  output logic               plot,
  output logic               erase,
  output logic               en_XY,
  output logic               frame_tick,
  output logic               wave_clear
);

  logic [2:0]           state_reg;
  logic [IDX_W-1:0]     sel_reg;
  logic [N_ENEMY-1:0]   snap_reg;
  logic                 frame_tick_reg;
  logic                 wave_clear_reg;

  logic [MAX_ENEMY-1:0] snap_ext;
  logic [MAX_ENEMY-1:0] alive_ext;
  logic [3:0]           sel_ext;
  bit_sel_t             nxt_snap;
  bit_sel_t             first_snap;
  bit_sel_t             first_alive;
  logic                 cnt_load;
  logic                 cnt_en;
  logic                 cnt_zero;

  always_comb begin
    snap_ext                 = '0;
    snap_ext[N_ENEMY-1:0]    = snap_reg;
    alive_ext                = '0;
    alive_ext[N_ENEMY-1:0]   = alive;
    sel_ext                  = '0;
    sel_ext[IDX_W-1:0]       = sel_reg;
    nxt_snap                 = next_set(snap_ext, sel_ext);
    first_snap               = first_set(snap_ext);
    first_alive              = first_set(alive_ext);
  end

  assign cnt_load = (state_reg == ST_DRAW) && done && !nxt_snap.valid;
  assign cnt_en   = (state_reg == ST_DELAY) && !pause;

  frame_delay_cnt #(
    .CNT_W     (CNT_W),
    .DELAY_CYC (DELAY_CYC)
  ) u_delay (
    .clk     (clk),
    .reset_N (reset_N),
    .load    (cnt_load),
    .en      (cnt_en),
    .zero    (cnt_zero)
  );

  // Every phase walks the frozen snapshot, so a mid-frame kill still gets erased.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_reg      <= ST_IDLE;
      sel_reg        <= '0;
      snap_reg       <= '0;
      frame_tick_reg <= 1'b0;
      wave_clear_reg <= 1'b0;
    end else begin
      frame_tick_reg <= 1'b0;
      wave_clear_reg <= 1'b0;
      case (state_reg)
        ST_IDLE:  if (go) state_reg <= ST_ARMED;
        ST_ARMED: if (!go) state_reg <= ST_LATCH;
        ST_LATCH: begin
          snap_reg <= alive;
          if (alive == '0) begin
            wave_clear_reg <= 1'b1;
            state_reg      <= ST_IDLE;
          end else begin
            sel_reg   <= first_alive.idx[IDX_W-1:0];
            state_reg <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (done) begin
            if (nxt_snap.valid) sel_reg <= nxt_snap.idx[IDX_W-1:0];
            else                state_reg <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (cnt_zero && !pause) begin
            sel_reg   <= first_snap.idx[IDX_W-1:0];
            state_reg <= ST_ERASE;
          end
        end
        ST_ERASE: begin
          if (done) begin
            if (nxt_snap.valid) begin
              sel_reg <= nxt_snap.idx[IDX_W-1:0];
            end else begin
              sel_reg   <= first_snap.idx[IDX_W-1:0];
              state_reg <= ST_UPDATE;
            end
          end
        end
        ST_UPDATE: begin
          if (nxt_snap.valid) begin
            sel_reg <= nxt_snap.idx[IDX_W-1:0];
          end else begin
            frame_tick_reg <= 1'b1;
            state_reg      <= ST_LATCH;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign sel        = sel_reg;
  assign plot       = (state_reg == ST_DRAW) || (state_reg == ST_ERASE);
  assign erase      = (state_reg == ST_ERASE);
  assign en_XY      = (state_reg == ST_UPDATE);
  assign frame_tick = frame_tick_reg;
  assign wave_clear = wave_clear_reg;

endmodule
